// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the two requester command/response channels and the memory
//   command/data signals that surround mem_port_arbiter.
//
//   Requester channel (x = a | b):
//     x_valid      command valid (requester drives)
//     x_ready      command accepted this cycle (arbiter drives)
//     x_we         1 = write, 0 = read
//     x_addr       command address
//     x_wdata      write data
//     x_rsp_valid  one-cycle read response pulse (arbiter drives)
//     x_rsp_data   read response data (arbiter drives)
//   Memory side:
//     mem_we / mem_re / mem_addr / mem_wdata   command to the memory
//     mem_rdata    registered memory output, valid one cycle after mem_re
//
//   Modports:
//     slave  - the arbiter's view
//     master - the surrounding environment (requesters plus memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  a_valid;
    logic                  a_ready;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_rsp_valid;
    logic [DATA_WIDTH-1:0] a_rsp_data;

    logic                  b_valid;
    logic                  b_ready;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_rsp_valid;
    logic [DATA_WIDTH-1:0] b_rsp_data;

    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rsp_valid, a_rsp_data,
        input  b_valid, b_we, b_addr, b_wdata,
        output b_ready, b_rsp_valid, b_rsp_data,
        output mem_we, mem_re, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rsp_valid, a_rsp_data,
        output b_valid, b_we, b_addr, b_wdata,
        input  b_ready, b_rsp_valid, b_rsp_data,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter sharing one single-port synchronous memory between
//   two requesters (A = index 0, B = index 1). Commands are granted within
//   the cycle they are presented, one per cycle; reads return exactly one
//   cycle after acceptance on the owning requester's response channel.
//
// Ports:
//   clk    rising-edge clock
//   rst_b  synchronous reset, active low
//   bus    mem_port_arbiter_if.slave: both requester channels + memory side
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_b,
    mem_port_arbiter_if.slave      bus
);
    localparam int NUM_REQ = 2;

    // Requester inputs gathered into arrays so per-requester logic can be
    // generated uniformly.
    logic                  req_valid [NUM_REQ];
    logic                  req_we    [NUM_REQ];
    logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];

    assign req_valid[0] = bus.a_valid;
    assign req_we[0]    = bus.a_we;
    assign req_addr[0]  = bus.a_addr;
    assign req_wdata[0] = bus.a_wdata;
    assign req_valid[1] = bus.b_valid;
    assign req_we[1]    = bus.b_we;
    assign req_addr[1]  = bus.b_addr;
    assign req_wdata[1] = bus.b_wdata;

    // State: last granted id (0=A, 1=B), read pending flag and its owner.
    logic last_grant_reg, last_grant_next;
    logic rd_pend_reg,    rd_pend_next;
    logic rd_owner_reg,   rd_owner_next;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] we_hit;
    logic [NUM_REQ-1:0] re_hit;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               any_grant;
    logic               grant_id;
    logic               mem_re_int;

    // Grant: a lone requester always wins; on a tie the requester that was
    // not granted last wins. Reset suppresses every grant.
    always_comb begin
        grant = '0;
        if (rst_b) begin
            if (req_valid[0] && (!req_valid[1] || last_grant_reg)) begin
                grant[0] = 1'b1;
            end else if (req_valid[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign any_grant = |grant;
    assign grant_id  = grant[1];

    // Per-requester command decode. AND-ing with the grant bit first keeps an
    // unknown we on an ungranted requester from reaching mem_we/mem_re.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign we_hit[gi]    = grant[gi] &  req_we[gi];
            assign re_hit[gi]    = grant[gi] & ~req_we[gi];
            assign rsp_valid[gi] = rst_b & rd_pend_reg & (rd_owner_reg == 1'(gi));
        end
    endgenerate

    assign mem_re_int = |re_hit;

    // Address/data mux selects on grant[1] only, so with no grant (or with A
    // granted) the A payload is presented and B's payload never leaks out.
    assign bus.mem_we    = |we_hit;
    assign bus.mem_re    = mem_re_int;
    assign bus.mem_addr  = grant[1] ? req_addr[1]  : req_addr[0];
    assign bus.mem_wdata = grant[1] ? req_wdata[1] : req_wdata[0];

    assign bus.a_ready = grant[0];
    assign bus.b_ready = grant[1];

    // Memory output is registered, so the response needs no extra pipeline:
    // it is simply routed to whichever requester issued last cycle's read.
    assign bus.a_rsp_valid = rsp_valid[0];
    assign bus.b_rsp_valid = rsp_valid[1];
    assign bus.a_rsp_data  = bus.mem_rdata;
    assign bus.b_rsp_data  = bus.mem_rdata;

    always_comb begin
        last_grant_next = last_grant_reg;
        rd_owner_next   = rd_owner_reg;
        rd_pend_next    = mem_re_int;
        if (any_grant) begin
            last_grant_next = grant_id;
            rd_owner_next   = grant_id;
        end
    end

    // Reset restores last_grant to B so that A wins the first tie, and drops
    // any read accepted just before reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            last_grant_reg <= 1'b1;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
            rd_pend_reg    <= rd_pend_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic clk;
    logic rst_b;
    int   total_cnt;
    int   pass_cnt;

    mem_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with registered read.
    logic [7:0] mem_model [64];
    always @(posedge clk) begin
        if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem_model[bus.mem_addr];
    end

    // {a_ready, b_ready, mem_we, mem_re, mem_addr, mem_wdata}
    function automatic logic [17:0] cmd_vec();
        return {bus.a_ready, bus.b_ready, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata};
    endfunction

    // {a_ready, b_ready, mem_we, mem_re, a_rsp_valid, b_rsp_valid}
    function automatic logic [5:0] ctl_vec();
        return {bus.a_ready, bus.b_ready, bus.mem_we, bus.mem_re, bus.a_rsp_valid, bus.b_rsp_valid};
    endfunction

    // {a_rsp_valid, b_rsp_valid, a_rsp_data, b_rsp_data}
    function automatic logic [17:0] rsp_vec();
        return {bus.a_rsp_valid, bus.b_rsp_valid, bus.a_rsp_data, bus.b_rsp_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [5:0] addr, input logic [7:0] d);
        bus.a_valid = v; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [5:0] addr, input logic [7:0] d);
        bus.b_valid = v; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst_b = 1'b0;
        drive_a(1'b1, 1'b0, 6'h01, 8'h00);
        drive_b(1'b1, 1'b1, 6'h02, 8'h33);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            got = ctl_vec();
            total_cnt++;
            if (got !== 6'b0) $display("FAIL reset_hold[%0d] ctl=%b exp=000000", i, got);
            else pass_cnt++;
        end
        tick();
        rst_b = 1'b1;
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        drive_b(1'b0, 1'b0, 6'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = ctl_vec();
            total_cnt++;
            if (got !== 6'b0) $display("FAIL reset_idle[%0d] ctl=%b exp=000000", i, got);
            else pass_cnt++;
            tick();
        end
        $display("[%0t] reset released, idle", $time);
    endtask

    task automatic test_write_read();
        logic [17:0] got;
        drive_a(1'b1, 1'b1, 6'h03, 8'h5A);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b1010, 6'h03, 8'h5A}) $display("FAIL wr_cmd got=%h exp=%h", got, {4'b1010, 6'h03, 8'h5A});
        else pass_cnt++;
        $display("[%0t] A write 0x5A @ 0x03", $time);
        tick();
        drive_a(1'b1, 1'b0, 6'h03, 8'h00);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b1001, 6'h03, 8'h00}) $display("FAIL rd_cmd got=%h exp=%h", got, {4'b1001, 6'h03, 8'h00});
        else pass_cnt++;
        $display("[%0t] A read @ 0x03", $time);
        tick();
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        got = rsp_vec();
        total_cnt++;
        if (got !== {2'b10, 8'h5A, 8'h5A}) $display("FAIL rd_rsp got=%h exp=%h", got, {2'b10, 8'h5A, 8'h5A});
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
            $display("FAIL rsp_pulse got=%b exp=00", {bus.a_rsp_valid, bus.b_rsp_valid});
        else pass_cnt++;
        $display("[%0t] A response 0x%h", $time, bus.a_rsp_data);
    endtask

    task automatic test_fairness();
        logic [17:0] got;
        logic [17:0] exp_cmd [4];
        logic [17:0] exp_rsp [5];
        // Seed two locations, one from each requester alone.
        tick();
        drive_a(1'b1, 1'b1, 6'h10, 8'h11);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b1010, 6'h10, 8'h11}) $display("FAIL seed_a got=%h exp=%h", got, {4'b1010, 6'h10, 8'h11});
        else pass_cnt++;
        tick();
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        drive_b(1'b1, 1'b1, 6'h20, 8'h22);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b0110, 6'h20, 8'h22}) $display("FAIL seed_b got=%h exp=%h", got, {4'b0110, 6'h20, 8'h22});
        else pass_cnt++;
        // last grant is now B, so the first tie goes to A.
        exp_cmd[0] = {4'b1001, 6'h10, 8'h00};
        exp_cmd[1] = {4'b0101, 6'h20, 8'h00};
        exp_cmd[2] = {4'b1001, 6'h10, 8'h00};
        exp_cmd[3] = {4'b0101, 6'h20, 8'h00};
        exp_rsp[1] = {2'b10, 8'h11, 8'h11};
        exp_rsp[2] = {2'b01, 8'h22, 8'h22};
        exp_rsp[3] = {2'b10, 8'h11, 8'h11};
        exp_rsp[4] = {2'b01, 8'h22, 8'h22};
        tick();
        drive_a(1'b1, 1'b0, 6'h10, 8'h00);
        drive_b(1'b1, 1'b0, 6'h20, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                drive_a(1'b0, 1'b0, 6'h00, 8'h00);
                drive_b(1'b0, 1'b0, 6'h00, 8'h00);
            end
            @(negedge clk);
            if (i < 4) begin
                got = cmd_vec();
                total_cnt++;
                if (got !== exp_cmd[i]) $display("FAIL rr_cmd[%0d] got=%h exp=%h", i, got, exp_cmd[i]);
                else pass_cnt++;
            end
            if (i > 0) begin
                got = rsp_vec();
                total_cnt++;
                if (got !== exp_rsp[i]) $display("FAIL rr_rsp[%0d] got=%h exp=%h", i, got, exp_rsp[i]);
                else pass_cnt++;
            end
            $display("[%0t] tie cycle %0d ready a=%b b=%b", $time, i, bus.a_ready, bus.b_ready);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] got;
        drive_a(1'b1, 1'b0, 6'h03, 8'h00);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b1001, 6'h03, 8'h00}) $display("FAIL b2b_cmd0 got=%h exp=%h", got, {4'b1001, 6'h03, 8'h00});
        else pass_cnt++;
        tick();
        drive_a(1'b1, 1'b0, 6'h10, 8'h00);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b1001, 6'h10, 8'h00}) $display("FAIL b2b_cmd1 got=%h exp=%h", got, {4'b1001, 6'h10, 8'h00});
        else pass_cnt++;
        got = rsp_vec();
        total_cnt++;
        if (got !== {2'b10, 8'h5A, 8'h5A}) $display("FAIL b2b_rsp0 got=%h exp=%h", got, {2'b10, 8'h5A, 8'h5A});
        else pass_cnt++;
        tick();
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        got = rsp_vec();
        total_cnt++;
        if (got !== {2'b10, 8'h11, 8'h11}) $display("FAIL b2b_rsp1 got=%h exp=%h", got, {2'b10, 8'h11, 8'h11});
        else pass_cnt++;
        $display("[%0t] A back-to-back reads 0x03, 0x10", $time);
        tick();
    endtask

    task automatic test_top_address();
        logic [17:0] got;
        // A idle with an unknown payload; it must not leak onto mem_*.
        bus.a_valid = 1'b0; bus.a_we = 1'bx; bus.a_addr = 6'bx; bus.a_wdata = 8'bx;
        drive_b(1'b1, 1'b1, 6'h3F, 8'hFF);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b0110, 6'h3F, 8'hFF}) $display("FAIL top_wr got=%h exp=%h", got, {4'b0110, 6'h3F, 8'hFF});
        else pass_cnt++;
        $display("[%0t] B write 0xFF @ 0x3F", $time);
        tick();
        drive_b(1'b1, 1'b0, 6'h3F, 8'h00);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b0101, 6'h3F, 8'h00}) $display("FAIL top_rd got=%h exp=%h", got, {4'b0101, 6'h3F, 8'h00});
        else pass_cnt++;
        tick();
        drive_b(1'b0, 1'b0, 6'h00, 8'h00);
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        got = rsp_vec();
        total_cnt++;
        if (got !== {2'b01, 8'hFF, 8'hFF}) $display("FAIL top_rsp got=%h exp=%h", got, {2'b01, 8'hFF, 8'hFF});
        else pass_cnt++;
        $display("[%0t] B response 0x%h", $time, bus.b_rsp_data);
        tick();
    endtask

    task automatic test_reset_drop();
        logic [17:0] got;
        drive_a(1'b1, 1'b0, 6'h03, 8'h00);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b1001, 6'h03, 8'h00}) $display("FAIL drop_cmd got=%h exp=%h", got, {4'b1001, 6'h03, 8'h00});
        else pass_cnt++;
        tick();
        rst_b = 1'b0;
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
                $display("FAIL drop_rsp[%0d] got=%b exp=00", i, {bus.a_rsp_valid, bus.b_rsp_valid});
            else pass_cnt++;
            tick();
        end
        rst_b = 1'b1;
        // A was granted last before reset; reset must make A win this tie.
        drive_a(1'b1, 1'b0, 6'h10, 8'h00);
        drive_b(1'b1, 1'b0, 6'h20, 8'h00);
        @(negedge clk);
        got = cmd_vec();
        total_cnt++;
        if (got !== {4'b1001, 6'h10, 8'h00}) $display("FAIL post_rst_tie got=%h exp=%h", got, {4'b1001, 6'h10, 8'h00});
        else pass_cnt++;
        total_cnt++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid} !== 2'b00)
            $display("FAIL post_rst_rsp got=%b exp=00", {bus.a_rsp_valid, bus.b_rsp_valid});
        else pass_cnt++;
        $display("[%0t] post-reset tie ready a=%b b=%b", $time, bus.a_ready, bus.b_ready);
        tick();
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        drive_b(1'b0, 1'b0, 6'h00, 8'h00);
        @(negedge clk);
        got = rsp_vec();
        total_cnt++;
        if (got !== {2'b10, 8'h11, 8'h11}) $display("FAIL post_rst_data got=%h exp=%h", got, {2'b10, 8'h11, 8'h11});
        else pass_cnt++;
        tick();
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_b = 1'b0;
        drive_a(1'b0, 1'b0, 6'h00, 8'h00);
        drive_b(1'b0, 1'b0, 6'h00, 8'h00);
        test_reset();
        test_write_read();
        test_fairness();
        test_back_to_back();
        test_top_address();
        test_reset_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
